rx_rd_arb: RTL and testbench

// - Shares the single read port of the RX frame buffer RAM among three requesters: load (header fetch), ack and pass.
// - Requests are single-cycle pulses from the RX control FSM and are held pending until served.
// - Serves one request at a time as a sequential burst and returns the data on a common byte bus with consumer select, SOF and EOF.

---
 rtl/rx_rd_arb.sv | 217 +++++++++++++++++++++
 tb/tb_rx_rd_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_rd_arb.sv
// rx_rd_arb: arbiter for the single read port of the RX frame buffer RAM.
// Three requesters (load = header fetch, ack, pass) post single-cycle
// requests. These are held pending and served one at a time as sequential
// bursts from address 0. The data returns on a shared byte bus tagged with
// consumer select, SOF and EOF.
// Build option: define RR_ARB_EN for round-robin arbitration among pending
// types. The default build uses fixed priority load > ack > pass.
module rx_rd_arb #(
  parameter int ADDR_W  = 9,
  parameter int HDR_LEN = 6
) (
  input  logic              sys_clk,
  input  logic              glbl_rst_n,
  input  logic              req_load,
  input  logic              req_ack,
  input  logic              req_pass,
  input  logic [ADDR_W:0]   frame_len,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic [7:0]        dout,
  output logic              dout_vld,
  output logic [1:0]        dout_sel,
  output logic              dout_sof,
  output logic              dout_eof,
  output logic              busy,
  output logic              done,
  output logic              req_drop
);

  localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] HDR_LEN_W = HDR_LEN[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      req_vec, clr_vec;
  logic            drop_q, drop_d;
  logic [1:0]      sel_q;
  logic [1:0]      gnt_idx;
  logic [ADDR_W:0] len_q, cnt_q, len_gnt;
  logic            last_addr;
  logic            drain_q;
  logic            vld_p0, sof_p0, eof_p0;
  logic [7:0]      dout_p1;
  logic            vld_p1, sof_p1, eof_p1;

  // Saturate a requested burst length to the size of the RAM
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] raw);
    return (raw > MAX_LEN) ? MAX_LEN : raw;
  endfunction

  // Length of the burst being granted; frame_len only matters in GRANT
  assign len_gnt   = clamp_len((sel_q == 2'b01) ? HDR_LEN_W : frame_len);
  assign last_addr = (cnt_q == (len_q - ONE));

`ifdef RR_ARB_EN
  logic [1:0] last_q;

  // Remember the last granted type; it gets lowest priority next time
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n)
      last_q <= 2'd2;
    else if (state_q == S_IDLE && (|pend_q))
      last_q <= gnt_idx;
  end

  // Round-robin pick starting just after the last granted type
  always_comb begin
    gnt_idx = 2'd0;
    case (last_q)
      2'd0:    gnt_idx = pend_q[1] ? 2'd1 : (pend_q[2] ? 2'd2 : 2'd0);
      2'd1:    gnt_idx = pend_q[2] ? 2'd2 : (pend_q[0] ? 2'd0 : 2'd1);
      default: gnt_idx = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
    endcase
  end
`else
  // Fixed priority pick: load > ack > pass
  always_comb begin
    gnt_idx = 2'd2;
    if (pend_q[0])
      gnt_idx = 2'd0;
    else if (pend_q[1])
      gnt_idx = 2'd1;
  end
`endif

  // Pending bits: set by requests, cleared when their burst leaves GRANT.
  // A same-type request during GRANT re-arms the bit instead of dropping.
  always_comb begin
    req_vec = {req_pass, req_ack, req_load};
    clr_vec = 3'b000;
    if (state_q == S_GRANT) begin
      case (sel_q)
        2'b01:   clr_vec = 3'b001;
        2'b10:   clr_vec = 3'b010;
        2'b11:   clr_vec = 3'b100;
        default: clr_vec = 3'b000;
      endcase
    end
    pend_d = (pend_q & ~clr_vec) | req_vec;
    drop_d = |(req_vec & pend_q & ~clr_vec);
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    ram_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pend_q)
          state_d = S_GRANT;
      end
      S_GRANT: begin
        busy    = 1'b1;
        state_d = (len_gnt == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        busy      = 1'b1;
        ram_rd_en = 1'b1;
        if (last_addr)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_q)
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: state, pending, grant select, length and address count
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 3'b000;
      drop_q  <= 1'b0;
      sel_q   <= 2'b00;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      case (state_q)
        S_IDLE: begin
          if (|pend_q)
            sel_q <= gnt_idx + 2'd1;
        end
        S_GRANT: begin
          len_q <= len_gnt;
          cnt_q <= '0;
        end
        S_READ:  cnt_q   <= cnt_q + ONE;
        S_DRAIN: drain_q <= ~drain_q;
        S_DONE: begin
          sel_q <= 2'b00;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Stage p0: RAM data valid this cycle, burst markers travel with it
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      vld_p0 <= 1'b0;
      sof_p0 <= 1'b0;
      eof_p0 <= 1'b0;
    end else begin
      vld_p0 <= ram_rd_en;
      sof_p0 <= ram_rd_en && (cnt_q == '0);
      eof_p0 <= ram_rd_en && last_addr;
    end
  end

  // Stage p1: registered output byte
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      dout_p1 <= 8'h00;
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      eof_p1  <= 1'b0;
    end else begin
      dout_p1 <= vld_p0 ? ram_rd_data : 8'h00;
      vld_p1  <= vld_p0;
      sof_p1  <= sof_p0;
      eof_p1  <= eof_p0;
    end
  end

  assign ram_rd_addr = cnt_q[ADDR_W-1:0];
  assign dout        = dout_p1;
  assign dout_vld    = vld_p1;
  assign dout_sof    = sof_p1;
  assign dout_eof    = eof_p1;
  assign dout_sel    = sel_q;
  assign req_drop    = drop_q;

endmodule

// File: tb/tb_rx_rd_arb.sv
// tb_rx_rd_arb: directed plus randomized bench for rx_rd_arb. A burst-level
// reference model predicts the grant order, the address and byte streams,
// and the done-pulse timing from the phase durations of each burst.
module tb_rx_rd_arb;

  localparam int ADDR_W  = 9;
  localparam int HDR_LEN = 6;
  localparam int MAXL    = 512;

  logic              sys_clk = 1'b0;
  logic              glbl_rst_n;
  logic              req_load, req_ack, req_pass;
  logic [ADDR_W:0]   frame_len;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [7:0]        ram_rd_data = 8'h00;
  logic [7:0]        dout;
  logic              dout_vld;
  logic [1:0]        dout_sel;
  logic              dout_sof, dout_eof;
  logic              busy, done, req_drop;

  rx_rd_arb #(.ADDR_W(ADDR_W), .HDR_LEN(HDR_LEN)) dut (
    .sys_clk     (sys_clk),
    .glbl_rst_n  (glbl_rst_n),
    .req_load    (req_load),
    .req_ack     (req_ack),
    .req_pass    (req_pass),
    .frame_len   (frame_len),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .dout_sel    (dout_sel),
    .dout_sof    (dout_sof),
    .dout_eof    (dout_eof),
    .busy        (busy),
    .done        (done),
    .req_drop    (req_drop)
  );

  always #5 sys_clk = ~sys_clk;

  // RAM with one cycle read latency
  logic [7:0] mem [0:MAXL-1];
  always @(posedge sys_clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } byte_t;

  // Monitor: records what the DUT produces
  byte_t obs_b[$];
  int    obs_addr[$];
  int    obs_done[$];
  int    mon_first_rd = -1;
  int    busy_cnt = 0, drop_cnt = 0, stray = 0;

  always @(negedge sys_clk) begin
    if (glbl_rst_n) begin
      if (dout_vld) obs_b.push_back({dout_sel, dout, dout_sof, dout_eof});
      else if (dout_sof || dout_eof) stray++;
      if (ram_rd_en) begin
        obs_addr.push_back(int'(ram_rd_addr));
        if (mon_first_rd < 0) mon_first_rd = cyc;
      end
      if (done) obs_done.push_back(cyc);
      if (busy) busy_cnt++;
      if (req_drop) drop_cnt++;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] outs();
    return {ram_rd_en, ram_rd_addr, dout, dout_vld, dout_sel, dout_sof, dout_eof,
            busy, done, req_drop};
  endfunction

  task automatic clear_mon();
    obs_b.delete(); obs_addr.delete(); obs_done.delete();
    mon_first_rd = -1; busy_cnt = 0; drop_cnt = 0; stray = 0;
  endtask

  // Reference model: burst order and lengths
  logic [1:0] exp_sel[$];
  int         exp_len[$];
  int         last_gnt = 2;

  function automatic int pick(input logic [2:0] m);
`ifdef RR_ARB_EN
    for (int i = 1; i <= 3; i++) begin
      int j;
      j = (last_gnt + i) % 3;
      if (m[j]) return j;
    end
`else
    for (int j = 0; j < 3; j++) if (m[j]) return j;
`endif
    return 0;
  endfunction

  // first_m pending at the first decision, late_m joins before the second
  task automatic model(input logic [2:0] first_m, input logic [2:0] late_m, input int flen);
    logic [2:0] p;
    int k;
    p = first_m;
    while (p != 3'b000) begin
      k = pick(p);
      exp_sel.push_back(2'(k + 1));
      exp_len.push_back(k == 0 ? HDR_LEN : (flen > MAXL ? MAXL : flen));
      p[k] = 1'b0;
      last_gnt = k;
      p = p | late_m;
      late_m = 3'b000;
    end
  endtask

  // Drive one request cycle; t = monitor cycle in which the request is pending
  task automatic pulse(input logic l, input logic a, input logic p, output int t);
    @(posedge sys_clk); #1;
    req_load = l; req_ack = a; req_pass = p;
    t = cyc + 1;
    @(posedge sys_clk); #1;
    req_load = 1'b0; req_ack = 1'b0; req_pass = 1'b0;
  endtask

  // Expected burst timing: GRANT 1 + READ L + DRAIN 2 + DONE 1, then IDLE 1;
  // zero length: GRANT 1 + DONE 1, then IDLE 1
  task automatic verify(input string tag, input int t0, input int exp_drop);
    int prev, first_rd, exp_busy, budget, nb, n;
    int ed[$];
    int ea[$];
    byte_t eb[$];
    prev = t0 - 1; first_rd = -1; exp_busy = 0;
    for (int i = 0; i < exp_len.size(); i++) begin
      int L;
      L = exp_len[i];
      if (L > 0) begin
        if (first_rd < 0) first_rd = prev + 3;
        for (int k = 0; k < L; k++) begin
          ea.push_back(k);
          eb.push_back({exp_sel[i], mem[k], (k == 0), (k == L - 1)});
        end
        prev = prev + 5 + L;
        exp_busy += L + 3;
      end else begin
        prev = prev + 3;
        exp_busy += 1;
      end
      ed.push_back(prev);
    end
    budget = prev - cyc + 40;
    while (obs_done.size() < ed.size() && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    repeat (6) @(negedge sys_clk);
    check({tag, ":done_cnt"}, obs_done.size(), ed.size());
    for (int i = 0; i < ed.size() && i < obs_done.size(); i++)
      check($sformatf("%s:done%0d_cyc", tag, i), obs_done[i], ed[i]);
    if (first_rd >= 0) check({tag, ":first_rd_cyc"}, mon_first_rd, first_rd);
    check({tag, ":addr_cnt"}, obs_addr.size(), ea.size());
    nb = 0;
    n = (ea.size() < obs_addr.size()) ? ea.size() : obs_addr.size();
    for (int i = 0; i < n; i++) if (obs_addr[i] != ea[i]) nb++;
    check({tag, ":addr_bad"}, nb, 0);
    check({tag, ":byte_cnt"}, obs_b.size(), eb.size());
    nb = 0;
    n = (eb.size() < obs_b.size()) ? eb.size() : obs_b.size();
    for (int i = 0; i < n; i++) if (obs_b[i] !== eb[i]) nb++;
    check({tag, ":byte_bad"}, nb, 0);
    check({tag, ":busy_cyc"}, busy_cnt, exp_busy);
    check({tag, ":drop_cnt"}, drop_cnt, exp_drop);
    check({tag, ":stray_mark"}, stray, 0);
    exp_sel.delete();
    exp_len.delete();
  endtask

  initial begin
    int t0, n, fl;
    for (int i = 0; i < MAXL; i++) mem[i] = 8'($urandom);
    req_load = 1'b0; req_ack = 1'b0; req_pass = 1'b0;
    frame_len = '0;
    glbl_rst_n = 1'b0;

    repeat (2) @(negedge sys_clk);
    check("rst_outputs", outs(), 26'd0);
    @(posedge sys_clk); #1 glbl_rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_outputs", outs(), 26'd0);

    // header fetch alone; frame_len must not matter
    clear_mon(); frame_len = 10'($urandom_range(0, 1023));
    model(3'b001, 3'b000, int'(frame_len));
    pulse(1'b1, 1'b0, 1'b0, t0);
    verify("load", t0, 0);

    // single-byte ack
    clear_mon(); frame_len = 10'd1;
    model(3'b010, 3'b000, 1);
    pulse(1'b0, 1'b1, 1'b0, t0);
    verify("ack_len1", t0, 0);

    // zero-length ack
    clear_mon(); frame_len = 10'd0;
    model(3'b010, 3'b000, 0);
    pulse(1'b0, 1'b1, 1'b0, t0);
    verify("ack_len0", t0, 0);

    // all three at once
    clear_mon(); fl = $urandom_range(1, 30); frame_len = 10'(fl);
    model(3'b111, 3'b000, fl);
    pulse(1'b1, 1'b1, 1'b1, t0);
    verify("all3", t0, 0);

    // pass requested twice while pending behind a load
    clear_mon(); fl = $urandom_range(1, 20); frame_len = 10'(fl);
    model(3'b001, 3'b100, fl);
    pulse(1'b1, 1'b0, 1'b0, t0);
    req_pass = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    req_pass = 1'b0;
    verify("drop", t0, 1);

    // oversize frame clamps to RAM size; later frame_len change ignored
    clear_mon(); frame_len = 10'd600;
    model(3'b100, 3'b000, 600);
    pulse(1'b0, 1'b0, 1'b1, t0);
    n = 0;
    while (!busy && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    @(posedge sys_clk); #1 frame_len = 10'($urandom_range(0, 100));
    verify("clamp", t0, 0);

    // randomized request sets and lengths
    for (int it = 0; it < 6; it++) begin
      logic [2:0] m;
      m  = 3'($urandom_range(1, 7));
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 700) : $urandom_range(0, 24);
      clear_mon(); frame_len = 10'(fl);
      model(m, 3'b000, fl);
      pulse(m[0], m[1], m[2], t0);
      verify($sformatf("rand%0d", it), t0, 0);
    end

    // reset in the middle of a burst, with a pass still pending
    clear_mon(); frame_len = 10'd40;
    pulse(1'b0, 1'b1, 1'b1, t0);
    n = 0;
    while (!(ram_rd_en && ram_rd_addr == 9'd10) && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    check("mid_rd_reached", (n < 40), 1);
    #2 glbl_rst_n = 1'b0;
    #1 check("rst_mid_outputs", outs(), 26'd0);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1 glbl_rst_n = 1'b1;
    last_gnt = 2;
    clear_mon(); fl = $urandom_range(1, 30); frame_len = 10'(fl);
    model(3'b010, 3'b000, fl);
    pulse(1'b0, 1'b1, 1'b0, t0);
    verify("after_rst", t0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
